ls259_ctrl: RTL and testbench
=============================

# ls259_ctrl

Sequencer and two-port arbiter for one clocked `ls259` addressable latch. Two requesters each submit a masked 8-bit write or a clear command over a valid/ready handshake. The block grants one requester at a time, round-robin, and walks the latch select lines bit by bit, never issuing the latch's illegal clear+enable encoding. It sits between the requesters and the `ls259` instance, shares `clk` with it, and keeps a shadow copy of the latch contents.

## Interface
- `GAP`, default 0: idle cycles inserted after each bit slot (0–7), for settle time.
- `clk`  in  1  system clock; also clocks the `ls259`.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  2  request valid; bit i belongs to requester i.
- `req_ready`  out  2  request accepted in this cycle when valid and ready are both high.
- `req_clr`  in  2  1 = clear command; data and mask are ignored.
- `req_data0`, `req_data1`  in  8  write data for requester 0 / 1.
- `req_mask0`, `req_mask1`  in  8  bit-write enables for requester 0 / 1.
- `S`  out  3  latch select, to `ls259.S`.
- `D`  out  1  latch data, to `ls259.D`.
- `En_b`  out  1  latch enable, active low, to `ls259.En_b`.
- `clr_b`  out  1  latch clear, active low, to `ls259.clr_b`.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when a granted command completes.
- `grant_id`  out  1  requester owning the current or most recent command.
- `shadow`  out  8  modelled latch contents.

## Operation
- States: INIT, IDLE, CLEAR, WRITE, GAP, DONE.
- Reset behaviour: `rst` forces state INIT asynchronously. Reset output values:
  - `clr_b`=0, `En_b`=1, `S`=0, `D`=0
  - `req_ready`=00, `busy`=1, `done`=0
  - `grant_id`=0, `shadow`=00, round-robin pointer favours requester 0
- INIT: lasts one cycle (drives latch clear, so `shadow` matches the latch), then goes to IDLE. INIT does not pulse `done`.
- IDLE outputs: `S`=0, `D`=0, `En_b`=1, `clr_b`=1.
- Arbitration in IDLE:
  - `req_ready`[i] is combinational: high only for the granted requester.
  - With one valid, that requester is granted.
  - With both valid, the requester opposite the last-granted one wins.
  - The pointer updates only on an accepted handshake.
  - Deasserting valid before acceptance is legal; no transfer occurs.
- On acceptance, the block captures data, mask and clr, sets `grant_id`, and moves to:
  - CLEAR, if clr=1;
  - DONE, if mask=00;
  - WRITE with bit index 0, otherwise.
- CLEAR: lasts one cycle with `clr_b`=0, `En_b`=1; `shadow`<=00; then DONE.
- WRITE, bit k:
  - Outputs: `S`=k, `D`=data[k], `En_b`=~mask[k], `clr_b`=1.
  - If mask[k]=1, `shadow`[k]<=data[k] on the same edge the latch samples.
  - Next state: GAP if `GAP`>0, else WRITE k+1.
  - After k=7 (and its gap), go to DONE.
- GAP: idle outputs (as in IDLE), held for `GAP` cycles.
- DONE: lasts one cycle; `done`=1, `req_ready`=00; then IDLE.
- Invariant: `clr_b`=0 and `En_b`=0 never occur together in any state.
- Masked-off bits still consume their slot, so write latency is fixed.

## Timing
- Handshake at edge T0 (valid and ready both high).
- Write (mask≠0):
  - WRITE bit k occupies cycle 1+k·(1+`GAP`).
  - DONE at cycle 8·(1+`GAP`)+1; IDLE at the following cycle.
  - With `GAP`=0: bits in cycles 1–8, DONE in cycle 9; the next acceptance can happen at the end of cycle 10 at the earliest.
- Clear: CLEAR in cycle 1, DONE in cycle 2.
- Mask=00: DONE in cycle 1.
- `shadow` and latch `Q` change on the same edge.
- `rst` asserted mid-command: the command is aborted immediately, with no `done`. After release, INIT clears the latch and `shadow`.

## Test plan
- Reset release, `GAP`=0:
  - INIT shows `clr_b`=0 for exactly one cycle, then IDLE outputs.
  - `shadow`=00, `done` never high.
- Requester 0 writes data A5, mask FF:
  - `S` steps 0..7 over cycles 1–8 with `D`=1,0,1,0,0,1,0,1 and `En_b`=0.
  - `done` in cycle 9; `shadow`=A5; latch `Q`=A5.
- Starting from `shadow`=A5, requester 1 writes data 00, mask 0F:
  - `En_b`=0 only in slots 0–3.
  - `shadow`=A0; `grant_id`=1.
- Both requesters valid continuously, each sending clear commands:
  - Grants alternate 0,1,0,1.
  - Each command shows one `clr_b`=0 cycle then `done` 2 cycles after acceptance.
  - `En_b`=0 never coincides with `clr_b`=0.
- `GAP`=2, mask 80, data 80:
  - Eight slots of 3 cycles each; only slot 7 has `En_b`=0.
  - `done` at cycle 25; `shadow`=80.
- Reset asserted during bit 3 of a write:
  - Outputs go to reset values immediately; no `done`.
  - After release, INIT clears; `shadow`=00 and latch `Q`=00.

Source files
------------

// File: rtl/ls259_ctrl.sv
// Purpose: two-port round-robin sequencer driving one clocked ls259 addressable latch bit by bit.
// Latency: write = 8*(1+GAP)+1 cycles to done, clear = 2, empty mask = 1; req_ready is combinational in IDLE.
// Backpressure: req_ready stays low outside IDLE; a requester holds req_valid until it sees its ready bit.
// Ports: req_* valid/ready command inputs (clr, data, mask per requester); S/D/En_b/clr_b drive the latch;
//        busy/done/grant_id report progress; shadow mirrors the latch contents.
module ls259_ctrl #(
    parameter int unsigned GAP = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [1:0] req_clr,
    input  logic [7:0] req_data0,
    input  logic [7:0] req_data1,
    input  logic [7:0] req_mask0,
    input  logic [7:0] req_mask1,
    output logic [2:0] S,
    output logic       D,
    output logic       En_b,
    output logic       clr_b,
    output logic       busy,
    output logic       done,
    output logic       grant_id,
    output logic [7:0] shadow
);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_CLEAR,
        ST_WRITE,
        ST_GAP,
        ST_DONE
    } state_t;

    // Reload value for the settle counter; only meaningful when GAP > 0.
    localparam logic [2:0] GAP_M1 = (GAP > 0) ? 3'(GAP - 1) : 3'd0;

    state_t     state_q, state_d;
    logic [2:0] bit_q, bit_d;
    logic [2:0] gap_q, gap_d;
    logic [7:0] data_q, data_d;
    logic [7:0] mask_q, mask_d;
    logic       grant_q, grant_d;
    logic       last_q, last_d;     // requester granted most recently
    logic [7:0] shadow_q, shadow_d;

    // With both valid the requester opposite the last grant wins; otherwise the only valid one.
    logic win;
    always_comb begin
        win = (req_valid == 2'b11) ? ~last_q : req_valid[1];
    end

    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        gap_d     = gap_q;
        data_d    = data_q;
        mask_d    = mask_q;
        grant_d   = grant_q;
        last_d    = last_q;
        shadow_d  = shadow_q;
        S         = 3'd0;
        D         = 1'b0;
        En_b      = 1'b1;
        clr_b     = 1'b1;
        req_ready = 2'b00;
        busy      = 1'b1;
        done      = 1'b0;

        case (state_q)
            ST_INIT: begin
                clr_b    = 1'b0;
                shadow_d = 8'h00;
                state_d  = ST_IDLE;
            end
            ST_IDLE: begin
                busy = 1'b0;
                if (|req_valid) begin
                    // The winner is always a valid requester, so raising its ready is an accept.
                    req_ready = win ? 2'b10 : 2'b01;
                    grant_d   = win;
                    last_d    = win;
                    data_d    = win ? req_data1 : req_data0;
                    mask_d    = win ? req_mask1 : req_mask0;
                    bit_d     = 3'd0;
                    if (req_clr[win]) begin
                        state_d = ST_CLEAR;
                    end else if ((win ? req_mask1 : req_mask0) == 8'h00) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_CLEAR: begin
                clr_b    = 1'b0;
                shadow_d = 8'h00;
                state_d  = ST_DONE;
            end
            ST_WRITE: begin
                S    = bit_q;
                D    = data_q[bit_q];
                En_b = ~mask_q[bit_q];
                // Shadow updates on the same edge the latch samples D.
                if (mask_q[bit_q]) begin
                    shadow_d[bit_q] = data_q[bit_q];
                end
                if (GAP > 0) begin
                    gap_d   = GAP_M1;
                    state_d = ST_GAP;
                end else if (bit_q == 3'd7) begin
                    state_d = ST_DONE;
                end else begin
                    bit_d = bit_q + 3'd1;
                end
            end
            ST_GAP: begin
                if (gap_q == 3'd0) begin
                    if (bit_q == 3'd7) begin
                        state_d = ST_DONE;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        state_d = ST_WRITE;
                    end
                end else begin
                    gap_d = gap_q - 3'd1;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_INIT;
            bit_q    <= 3'd0;
            gap_q    <= 3'd0;
            data_q   <= 8'h00;
            mask_q   <= 8'h00;
            grant_q  <= 1'b0;
            last_q   <= 1'b1;   // so requester 0 wins the first contended round
            shadow_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            gap_q    <= gap_d;
            data_q   <= data_d;
            mask_q   <= mask_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            shadow_q <= shadow_d;
        end
    end

    assign grant_id = grant_q;
    assign shadow   = shadow_q;

endmodule

// File: tb/tb_ls259_ctrl.sv
// Purpose: self-checking bench for ls259_ctrl; instance 0 uses GAP=0, instance 1 uses GAP=2.
// Latency: a slot-schedule model predicts every output each cycle, checked on the falling edge.
// Backpressure: requests hold valid until ready is seen, bounded by a cycle budget.
module tb_ls259_ctrl;

    logic       clk;
    logic       rst;
    logic [1:0] req_valid [2];
    logic [1:0] req_ready [2];
    logic [1:0] req_clr   [2];
    logic [7:0] req_data0 [2];
    logic [7:0] req_data1 [2];
    logic [7:0] req_mask0 [2];
    logic [7:0] req_mask1 [2];
    logic [2:0] S         [2];
    logic       D         [2];
    logic       En_b      [2];
    logic       clr_b     [2];
    logic       busy      [2];
    logic       done      [2];
    logic       grant_id  [2];
    logic [7:0] shadow    [2];
    logic [7:0] latch_q   [2];

    int n_total = 0;
    int n_bad   = 0;
    bit chk_en  = 0;

    ls259_ctrl #(.GAP(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_clr(req_clr[0]),
        .req_data0(req_data0[0]), .req_data1(req_data1[0]),
        .req_mask0(req_mask0[0]), .req_mask1(req_mask1[0]),
        .S(S[0]), .D(D[0]), .En_b(En_b[0]), .clr_b(clr_b[0]),
        .busy(busy[0]), .done(done[0]), .grant_id(grant_id[0]), .shadow(shadow[0])
    );

    ls259_ctrl #(.GAP(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_clr(req_clr[1]),
        .req_data0(req_data0[1]), .req_data1(req_data1[1]),
        .req_mask0(req_mask0[1]), .req_mask1(req_mask1[1]),
        .S(S[1]), .D(D[1]), .En_b(En_b[1]), .clr_b(clr_b[1]),
        .busy(busy[1]), .done(done[1]), .grant_id(grant_id[1]), .shadow(shadow[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Clocked ls259 stand-in: clear wins, else enabled bit S takes D.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!clr_b[i]) latch_q[i] <= 8'h00;
            else if (!En_b[i]) latch_q[i][S[i]] <= D[i];
        end
    end

    // ---------------- behavioural model ----------------
    // Phase: 0 = init, 1 = idle, 2 = command in flight; m_t counts cycles since acceptance.
    // Kind: 0 = clear, 1 = write, 2 = empty mask.
    int         m_ph   [2];
    int         m_kind [2];
    int         m_t    [2];
    logic [7:0] m_data [2];
    logic [7:0] m_mask [2];
    logic [7:0] m_shad [2];
    logic       m_gid  [2];
    logic       m_last [2];

    function automatic int gap_of(input int i);
        return (i == 0) ? 0 : 2;
    endfunction

    function automatic int cmd_len(input int i);
        if (m_kind[i] == 0) return 2;
        if (m_kind[i] == 2) return 1;
        return 8 * (1 + gap_of(i)) + 1;
    endfunction

    // Bit index written in cycle t of a write, or -1 for a settle/done cycle.
    function automatic int slot_of(input int i, input int t);
        int p;
        p = 1 + gap_of(i);
        if (t >= 1 && t <= 8 * p && ((t - 1) % p) == 0) return (t - 1) / p;
        return -1;
    endfunction

    function automatic logic pick(input int i, input logic [1:0] v);
        if (v == 2'b11) return ~m_last[i];
        return v[1];
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_ph[i]   <= 0;
                m_shad[i] <= 8'h00;
                m_gid[i]  <= 1'b0;
                m_last[i] <= 1'b1;
            end else begin
                case (m_ph[i])
                    0: begin
                        m_shad[i] <= 8'h00;
                        m_ph[i]   <= 1;
                    end
                    1: begin
                        if (|req_valid[i]) begin
                            logic       w;
                            logic [7:0] mk;
                            w  = pick(i, req_valid[i]);
                            mk = w ? req_mask1[i] : req_mask0[i];
                            m_gid[i]  <= w;
                            m_last[i] <= w;
                            m_data[i] <= w ? req_data1[i] : req_data0[i];
                            m_mask[i] <= mk;
                            m_kind[i] <= req_clr[i][w] ? 0 : ((mk == 8'h00) ? 2 : 1);
                            m_t[i]    <= 1;
                            m_ph[i]   <= 2;
                        end
                    end
                    default: begin
                        int k;
                        k = slot_of(i, m_t[i]);
                        if (m_kind[i] == 0 && m_t[i] == 1) m_shad[i] <= 8'h00;
                        if (m_kind[i] == 1 && k >= 0 && m_mask[i][k]) m_shad[i][k] <= m_data[i][k];
                        if (m_t[i] == cmd_len(i)) m_ph[i] <= 1;
                        else m_t[i] <= m_t[i] + 1;
                    end
                endcase
            end
        end
    end

    // {ready, S, D, En_b, clr_b, busy, done, grant_id, shadow}
    function automatic logic [18:0] expect_out(input int i);
        logic [1:0] rdy;
        logic [2:0] s;
        logic       d, en, cl, bz, dn;
        int         k;
        rdy = 2'b00; s = 3'd0; d = 1'b0; en = 1'b1; cl = 1'b1; bz = 1'b1; dn = 1'b0;
        case (m_ph[i])
            0: cl = 1'b0;
            1: begin
                bz = 1'b0;
                if (|req_valid[i]) rdy = pick(i, req_valid[i]) ? 2'b10 : 2'b01;
            end
            default: begin
                if (m_kind[i] == 0 && m_t[i] == 1) cl = 1'b0;
                if (m_kind[i] == 1) begin
                    k = slot_of(i, m_t[i]);
                    if (k >= 0) begin
                        s  = 3'(k);
                        d  = m_data[i][k];
                        en = ~m_mask[i][k];
                    end
                end
                if (m_t[i] == cmd_len(i)) dn = 1'b1;
            end
        endcase
        return {rdy, s, d, en, cl, bz, dn, m_gid[i], m_shad[i]};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                logic [18:0] act, exp;
                act = {req_ready[i], S[i], D[i], En_b[i], clr_b[i], busy[i], done[i],
                       grant_id[i], shadow[i]};
                exp = expect_out(i);
                n_total++;
                if (act !== exp) begin
                    n_bad++;
                    $display("FAIL cycle_model inst%0d t=%0t: got %05h expected %05h", i, $time, act, exp);
                end
                n_total++;
                if (clr_b[i] === 1'b0 && En_b[i] === 1'b0) begin
                    n_bad++;
                    $display("FAIL clr_en_overlap inst%0d t=%0t: clr_b=0 with En_b=0", i, $time);
                end
            end
        end
    end

    // ---------------- monitors for literal checks ----------------
    bit grants [$];
    int clr_lo0 = 0;
    int en_lo1  = 0;

    always @(posedge clk) begin
        if (!rst && (req_valid[0] & req_ready[0]) != 2'b00) grants.push_back(req_ready[0][1]);
    end

    always @(negedge clk) begin
        if (!rst && clr_b[0] === 1'b0) clr_lo0++;
        if (!rst && En_b[1] === 1'b0) en_lo1++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input int i, input int who, input logic clr,
                        input logic [7:0] data, input logic [7:0] mask);
        bit ok;
        if (who == 0) begin
            req_data0[i] = data; req_mask0[i] = mask;
        end else begin
            req_data1[i] = data; req_mask1[i] = mask;
        end
        req_clr[i][who]   = clr;
        req_valid[i][who] = 1'b1;
        ok = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (req_ready[i][who] === 1'b1) begin
                ok = 1;
                break;
            end
        end
        if (ok) @(posedge clk);
        #1;
        req_valid[i][who] = 1'b0;
        chk("handshake_accepted", 32'(ok), 32'd1);
    endtask

    task automatic wait_done(input int i, output int cyc);
        cyc = -1;
        for (int c = 1; c < 100; c++) begin
            @(negedge clk);
            if (done[i] === 1'b1) begin
                cyc = c;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        bit  ok;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 2'b00; req_clr[i] = 2'b00;
            req_data0[i] = 8'h00; req_data1[i] = 8'h00;
            req_mask0[i] = 8'h00; req_mask1[i] = 8'h00;
        end
        rst = 1'b0;
        #1;
        rst    = 1'b1;
        chk_en = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // INIT: exactly one clear cycle, then idle outputs.
        @(negedge clk);
        chk("init_clr_b", 32'(clr_b[0]), 32'd0);
        chk("init_busy", 32'(busy[0]), 32'd1);
        @(negedge clk);
        chk("idle_clr_b", 32'(clr_b[0]), 32'd1);
        chk("idle_busy", 32'(busy[0]), 32'd0);
        chk("idle_shadow", 32'(shadow[0]), 32'h00);
        @(posedge clk);
        #1;

        // Requester 0 full write A5.
        send(0, 0, 1'b0, 8'hA5, 8'hFF);
        wait_done(0, cyc);
        chk("a5_done_cycle", 32'(cyc), 32'd9);
        chk("a5_shadow", 32'(shadow[0]), 32'hA5);
        chk("a5_latch", 32'(latch_q[0]), 32'hA5);

        // Requester 1 writes low nibble to zero.
        send(0, 1, 1'b0, 8'h00, 8'h0F);
        wait_done(0, cyc);
        chk("a0_done_cycle", 32'(cyc), 32'd9);
        chk("a0_shadow", 32'(shadow[0]), 32'hA0);
        chk("a0_grant_id", 32'(grant_id[0]), 32'd1);
        chk("a0_latch", 32'(latch_q[0]), 32'hA0);

        // Both requesters hammering clears.
        grants.delete();
        clr_lo0      = 0;
        req_clr[0]   = 2'b11;
        req_valid[0] = 2'b11;
        ok = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (grants.size() >= 4) begin
                ok = 1;
                break;
            end
        end
        req_valid[0] = 2'b00;
        req_clr[0]   = 2'b00;
        repeat (4) @(posedge clk);
        #1;
        chk("rr_four_grants", 32'(ok), 32'd1);
        if (grants.size() >= 4) begin
            chk("rr_grant0", 32'(grants[0]), 32'd0);
            chk("rr_grant1", 32'(grants[1]), 32'd1);
            chk("rr_grant2", 32'(grants[2]), 32'd0);
            chk("rr_grant3", 32'(grants[3]), 32'd1);
        end
        chk("rr_clr_cycles", 32'(clr_lo0), 32'd4);
        chk("rr_shadow", 32'(shadow[0]), 32'h00);
        chk("rr_latch", 32'(latch_q[0]), 32'h00);

        // GAP=2 instance: only bit 7 enabled.
        en_lo1 = 0;
        send(1, 0, 1'b0, 8'h80, 8'h80);
        wait_done(1, cyc);
        chk("gap2_done_cycle", 32'(cyc), 32'd25);
        chk("gap2_en_cycles", 32'(en_lo1), 32'd1);
        chk("gap2_shadow", 32'(shadow[1]), 32'h80);
        chk("gap2_latch", 32'(latch_q[1]), 32'h80);

        // Reset in the middle of bit 3 of a write.
        send(0, 0, 1'b0, 8'hFF, 8'hFF);
        ok = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (S[0] == 3'd3 && En_b[0] === 1'b0) begin
                ok = 1;
                break;
            end
        end
        chk("rst_reached_bit3", 32'(ok), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_outputs", 32'({req_ready[0], S[0], D[0], En_b[0], clr_b[0], busy[0], done[0],
                                grant_id[0], shadow[0]}),
            32'({2'b00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_init_clr_b", 32'(clr_b[0]), 32'd0);
        chk("rst_no_done", 32'(done[0]), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_shadow", 32'(shadow[0]), 32'h00);
        chk("rst_latch", 32'(latch_q[0]), 32'h00);
        repeat (2) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
